// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the matrix keypad scanner.
// Holds FSM encodings, matrix geometry and matrix helper functions.
package keypad_scanner_pkg;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;
    localparam int KEYS     = KEY_ROWS * KEY_COLS;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_MULTI   = 2'd2
    } state_t;

    function automatic logic [4:0] count_keys(input logic [KEYS-1:0] m);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < KEYS; i++) begin
            n = n + {4'b0000, m[i]};
        end
        return n;
    endfunction

    // The matrix is stored column-major (bit = col*4 + row) while key
    // codes are row-major (row*4 + col), so the two halves swap.
    function automatic logic [3:0] key_index(input logic [KEYS-1:0] m);
        logic [3:0] idx;
        logic [3:0] pos;
        idx = '0;
        for (int p = 0; p < KEYS; p++) begin
            pos = 4'(p);
            if (m[p]) begin
                idx = {pos[1:0], pos[3:2]};
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_tick_gen.sv
// scan_tick_gen: free-running divider producing a one-clk scan tick.
// Ports: i_clk, i_rst (sync, active-high), o_tick (high when count==DIVISOR-1).
module scan_tick_gen #(
    parameter int DIVISOR = 1350
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: strobes a 4x4 keypad, debounces full scans, reports single keys.
// Ports: clk, rst (sync, active-high), row_in[3:0] (active-low rows),
//        col_out[3:0] (active-low strobe), key_code[3:0], key_valid (pulse), key_held.
module keypad_scanner #(
    parameter int DIVISOR        = 1350,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    import keypad_scanner_pkg::*;

    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);
    localparam logic [SW-1:0] STABLE_ONE = SW'(1);

    logic            w_tick;
    logic            w_scan_done;
    logic            w_same;
    logic            w_commit;
    logic [KEYS-1:0] w_scan_next;
    logic [SW-1:0]   w_stable_next;
    logic [4:0]      w_n;
    logic [3:0]      w_idx;

    logic [1:0]      r_col_idx;
    logic [KEYS-1:0] r_scan;
    logic [KEYS-1:0] r_last;
    logic [KEYS-1:0] r_debounced;
    logic [SW-1:0]   r_stable_cnt;
    logic            r_commit;
    state_t          r_state;
    logic [3:0]      r_key_code;
    logic            r_key_valid;
    logic            r_key_held;

    scan_tick_gen #(
        .DIVISOR (DIVISOR)
    ) u_tick (
        .i_clk  (clk),
        .i_rst  (rst),
        .o_tick (w_tick)
    );

    assign col_out = ~(4'b0001 << r_col_idx);

    // Merge the current column sample so the end-of-scan compare
    // sees the complete matrix on the same clk.
    always_comb begin
        w_scan_next = r_scan;
        w_scan_next[{r_col_idx, 2'b00} +: 4] = ~row_in;
    end

    assign w_scan_done = w_tick && (r_col_idx == 2'd3);
    assign w_same      = (w_scan_next == r_last);

    always_comb begin
        w_stable_next = STABLE_ONE;
        if (w_same) begin
            if (r_stable_cnt == STABLE_MAX) begin
                w_stable_next = STABLE_MAX;
            end else begin
                w_stable_next = r_stable_cnt + 1'b1;
            end
        end
    end

    assign w_commit = w_scan_done && (w_stable_next == STABLE_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_idx    <= 2'd0;
            r_scan       <= '0;
            r_last       <= '0;
            r_debounced  <= '0;
            r_stable_cnt <= '0;
            r_commit     <= 1'b0;
        end else begin
            r_commit <= w_commit;
            if (w_tick) begin
                r_scan    <= w_scan_next;
                r_col_idx <= r_col_idx + 2'd1;
            end
            if (w_scan_done) begin
                r_last       <= w_scan_next;
                r_stable_cnt <= w_stable_next;
            end
            if (w_commit) begin
                r_debounced <= w_scan_next;
            end
        end
    end

    assign w_n   = count_keys(r_debounced);
    assign w_idx = key_index(r_debounced);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (r_commit) begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_n == 5'd1) begin
                            r_state     <= ST_PRESSED;
                            r_key_code  <= w_idx;
                            r_key_valid <= 1'b1;
                            r_key_held  <= 1'b1;
                        end else if (w_n > 5'd1) begin
                            r_state <= ST_MULTI;
                        end
                    end
                    ST_PRESSED: begin
                        if (w_n == 5'd0) begin
                            r_state    <= ST_IDLE;
                            r_key_held <= 1'b0;
                        end else if (w_n != 5'd1 || w_idx != r_key_code) begin
                            r_state    <= ST_MULTI;
                            r_key_held <= 1'b0;
                        end
                    end
                    ST_MULTI: begin
                        if (w_n == 5'd0) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_key_held <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner (DIVISOR=4, DEBOUNCE_SCANS=2).
// Drives a behavioural 4x4 keypad from a key mask and checks outputs directly.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = 16'h0000;

    int n_cmp = 0;
    int n_mis = 0;
    int n_pulse = 0;

    keypad_scanner #(
        .DIVISOR        (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its row low while its column is strobed.
    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (col_out[c] == 1'b0) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys[r*4+c]) row_in[r] = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && key_valid) n_pulse <= n_pulse + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int n, output logic found);
        found = 1'b0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (key_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(3);
        rst = 1'b0;
    endtask

    initial begin
        logic found;
        int   base;

        // 1. reset and column rotation
        rst = 1'b1;
        step(3);
        chk("rst_col", 16'(col_out), 16'hE);
        chk("rst_valid", 16'(key_valid), 16'h0);
        chk("rst_held", 16'(key_held), 16'h0);
        chk("rst_code", 16'(key_code), 16'h0);
        rst = 1'b0;
        step(3);
        chk("rot_c0", 16'(col_out), 16'hE);
        step(1);
        chk("rot_c1", 16'(col_out), 16'hD);
        step(4);
        chk("rot_c2", 16'(col_out), 16'hB);
        step(4);
        chk("rot_c3", 16'(col_out), 16'h7);
        step(4);
        chk("rot_wrap", 16'(col_out), 16'hE);

        // 2. single press of key 9 (row 2, col 1)
        base = n_pulse;
        keys = 16'h0200;
        wait_valid(50, found);
        chk("s2_found", 16'(found), 16'h1);
        chk("s2_code", 16'(key_code), 16'h9);
        chk("s2_held", 16'(key_held), 16'h1);
        step(1);
        chk("s2_valid_drop", 16'(key_valid), 16'h0);
        step(40);
        chk("s2_one_pulse", 16'(n_pulse - base), 16'h1);
        chk("s2_still_held", 16'(key_held), 16'h1);

        // 3. release
        base = n_pulse;
        keys = 16'h0000;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (key_held === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        chk("s3_released", 16'(found), 16'h1);
        step(2);
        chk("s3_no_pulse", 16'(n_pulse - base), 16'h0);
        chk("s3_code_kept", 16'(key_code), 16'h9);

        // 4. bounce on key 9, then steady hold
        do_reset();
        base = n_pulse;
        for (int i = 0; i < 16; i++) begin
            keys[9] = ~keys[9];
            step(12);
        end
        keys[9] = 1'b1;
        step(60);
        chk("s4_one_pulse", 16'(n_pulse - base), 16'h1);
        chk("s4_code", 16'(key_code), 16'h9);
        chk("s4_held", 16'(key_held), 16'h1);

        // 5. multi-key
        keys = 16'h0000;
        step(60);
        base = n_pulse;
        keys = 16'h0021;
        step(80);
        chk("s5_multi_pulse", 16'(n_pulse - base), 16'h0);
        chk("s5_multi_held", 16'(key_held), 16'h0);
        keys = 16'h0001;
        step(80);
        chk("s5_partial_pulse", 16'(n_pulse - base), 16'h0);
        chk("s5_partial_held", 16'(key_held), 16'h0);
        keys = 16'h0000;
        step(60);
        keys = 16'h0008;
        wait_valid(50, found);
        chk("s5_k3_found", 16'(found), 16'h1);
        chk("s5_k3_code", 16'(key_code), 16'h3);
        step(20);
        chk("s5_k3_one_pulse", 16'(n_pulse - base), 16'h1);

        // 6. reset while key 9 is held
        keys = 16'h0000;
        step(60);
        keys = 16'h0200;
        wait_valid(50, found);
        chk("s6_pre_found", 16'(found), 16'h1);
        chk("s6_pre_held", 16'(key_held), 16'h1);
        rst = 1'b1;
        step(3);
        chk("s6_rst_code", 16'(key_code), 16'h0);
        chk("s6_rst_valid", 16'(key_valid), 16'h0);
        chk("s6_rst_held", 16'(key_held), 16'h0);
        chk("s6_rst_col", 16'(col_out), 16'hE);
        rst = 1'b0;
        base = n_pulse;
        wait_valid(50, found);
        chk("s6_re_found", 16'(found), 16'h1);
        chk("s6_re_code", 16'(key_code), 16'h9);
        chk("s6_re_held", 16'(key_held), 16'h1);
        step(20);
        chk("s6_re_one_pulse", 16'(n_pulse - base), 16'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
